// File: rtl/int_seq_if.sv
// Signal bundle between the cycle controller (master) and the interrupt sequencer (slave).
interface int_seq_if;
  logic        nmi_n;
  logic        irq_n;
  logic        iflag;
  logic        sync;
  logic        brk;
  logic        ready;
  logic        irq_force;
  logic        busy;
  logic [2:0]  step;
  logic [15:0] vec_addr;
  logic        stack_wr;
  logic        b_flag;
  logic        set_i;

  modport master (
    output nmi_n, irq_n, iflag, sync, brk, ready,
    input  irq_force, busy, step, vec_addr, stack_wr, b_flag, set_i
  );

  modport slave (
    input  nmi_n, irq_n, iflag, sync, brk, ready,
    output irq_force, busy, step, vec_addr, stack_wr, b_flag, set_i
  );
endinterface

// File: rtl/int_seq.sv
// Interrupt/reset/BRK sequencer: RESET > NMI > IRQ arbitration, push and vector-fetch steps.
// Define INT_SYNC2_EN to pass nmi_n/irq_n through a two-flop synchroniser.
module int_seq (
  input logic      clk,
  input logic      rst,
  int_seq_if.slave bus
);
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StPch  = 3'd1,
    StPcl  = 3'd2,
    StP    = 3'd3,
    StVl   = 3'd4,
    StVh   = 3'd5
  } state_e;

  typedef enum logic [1:0] {SrcReset, SrcNmi, SrcIrq, SrcBrk} src_e;

  localparam logic [15:0] VecNmi   = 16'hFFFA;
  localparam logic [15:0] VecReset = 16'hFFFC;
  localparam logic [15:0] VecIrq   = 16'hFFFE;

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic [15:0] base_q, base_d;
  logic        rst_pend_q, rst_pend_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        nmi_s_q, nmi_prev_q, irq_s_q;
  logic        nmi_edge, irq_act, pend_now, pre_vec, irq_force;

`ifdef INT_SYNC2_EN
  logic nmi_m_q, irq_m_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_m_q    <= 1'b1;
      nmi_s_q    <= 1'b1;
      nmi_prev_q <= 1'b1;
      irq_m_q    <= 1'b1;
      irq_s_q    <= 1'b1;
    end else begin
      nmi_m_q    <= bus.nmi_n;
      nmi_s_q    <= nmi_m_q;
      nmi_prev_q <= nmi_s_q;
      irq_m_q    <= bus.irq_n;
      irq_s_q    <= irq_m_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_s_q    <= 1'b1;
      nmi_prev_q <= 1'b1;
      irq_s_q    <= 1'b1;
    end else begin
      nmi_s_q    <= bus.nmi_n;
      nmi_prev_q <= nmi_s_q;
      irq_s_q    <= bus.irq_n;
    end
  end
`endif

  assign nmi_edge = nmi_prev_q & ~nmi_s_q;
  assign irq_act  = ~irq_s_q & ~bus.iflag;
  // An edge seen this cycle already counts for hijack and is consumed with the pending bit.
  assign pend_now = nmi_pend_q | nmi_edge;
  assign pre_vec  = state_q inside {StPch, StPcl, StP};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      src_q      <= SrcReset;
      base_q     <= 16'h0000;
      rst_pend_q <= 1'b1;
      nmi_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      base_q     <= base_d;
      rst_pend_q <= rst_pend_d;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    base_d     = base_q;
    rst_pend_d = rst_pend_q;
    nmi_pend_d = pend_now;
    irq_force  = (state_q == StIdle) & bus.sync & bus.ready & (rst_pend_q | nmi_pend_q | irq_act);
    if (bus.ready) begin
      unique case (state_q)
        StIdle: begin
          if (irq_force) begin
            state_d = StPch;
            if (rst_pend_q) begin
              src_d  = SrcReset;
              base_d = VecReset;
            end else if (nmi_pend_q) begin
              src_d  = SrcNmi;
              base_d = VecNmi;
            end else begin
              src_d  = SrcIrq;
              base_d = VecIrq;
            end
          end else if (bus.brk) begin
            state_d = StPch;
            src_d   = SrcBrk;
            base_d  = VecIrq;
          end
        end
        StPch:   state_d = StPcl;
        StPcl:   state_d = StP;
        StP:     state_d = StVl;
        StVl:    state_d = StVh;
        StVh:    state_d = StIdle;
        default: state_d = StIdle;
      endcase
      // NMI arriving before the vector fetch steals an IRQ/BRK sequence.
      if (pre_vec && (src_q == SrcIrq || src_q == SrcBrk) && pend_now) begin
        base_d = VecNmi;
      end
      if (state_q == StP) begin
        if (base_d == VecNmi) nmi_pend_d = 1'b0;
        if (src_q == SrcReset) rst_pend_d = 1'b0;
      end
    end
  end

  always_comb begin
    bus.irq_force = irq_force;
    bus.busy      = (state_q != StIdle);
    bus.step      = state_q;
    bus.stack_wr  = pre_vec && (src_q != SrcReset);
    bus.b_flag    = (state_q == StP) && (src_q == SrcBrk);
    bus.set_i     = (state_q == StVh);
    bus.vec_addr  = 16'h0000;
    if (state_q == StVl) bus.vec_addr = base_q;
    if (state_q == StVh) bus.vec_addr = base_q + 16'd1;
  end
endmodule

// File: tb/tb_int_seq.sv
// Cycle-table bench for int_seq: each row drives one cycle of inputs and expects that cycle's outputs.
module tb_int_seq;
  logic clk = 1'b0;
  logic rst;

  int_seq_if bus ();

  int_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // in = {rst, sync, brk, ready, irq_n, iflag, nmi_n}
  // exp = {irq_force, busy, step[2:0], vec_addr[15:0], stack_wr, b_flag, set_i}
  typedef struct {
    logic [6:0]  in;
    logic [23:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [23:0] sb[$];
  int          checks   = 0;
  int          failures = 0;
  bit          done     = 1'b0;

  function automatic logic [23:0] pack(input bit f, input int st, input bit sw, input bit bf,
                                       input bit si, input logic [15:0] va);
    logic [2:0] s;
    s = st[2:0];
    return {f, (s != 3'd0), s, va, sw, bf, si};
  endfunction

  task automatic add(input logic [6:0] in, input bit f, input int st, input bit sw, input bit bf,
                     input bit si, input logic [15:0] va);
    vec_t v;
    v.in  = in;
    v.exp = pack(f, st, sw, bf, si, va);
    tbl.push_back(v);
  endtask

  task automatic apply(input logic [6:0] in);
    rst       = in[6];
    bus.sync  = in[5];
    bus.brk   = in[4];
    bus.ready = in[3];
    bus.irq_n = in[2];
    bus.iflag = in[1];
    bus.nmi_n = in[0];
  endtask

  logic [23:0] act, exp;

  initial begin
    #100000;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL timeout: table run did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    // Reset, then power-on reset sequence
    add(7'b1_0_0_1_1_1_1, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_1_0_1_1_1_1, 1, 0, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 1, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 2, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 3, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 4, 0, 0, 0, 16'hFFFC);
    add(7'b0_0_0_1_1_1_1, 0, 5, 0, 0, 1, 16'hFFFD);
    add(7'b0_1_0_1_1_1_1, 0, 0, 0, 0, 0, 16'h0000);
    // IRQ masked by iflag, then taken
    add(7'b0_0_0_1_0_1_1, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_1_0_1_0_1_1, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_1_0_1_0_1_1, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_1_0_1_0_0_1, 1, 0, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_0_1, 0, 1, 1, 0, 0, 16'h0000);
    add(7'b0_1_1_1_1_0_1, 0, 2, 1, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_0_1, 0, 3, 1, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_0_1, 0, 4, 0, 0, 0, 16'hFFFE);
    add(7'b0_0_0_1_1_0_1, 0, 5, 0, 0, 1, 16'hFFFF);
    add(7'b0_0_0_1_1_1_1, 0, 0, 0, 0, 0, 16'h0000);
    // BRK
    add(7'b0_0_1_1_1_1_1, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 1, 1, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 2, 1, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 3, 1, 1, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 4, 0, 0, 0, 16'hFFFE);
    add(7'b0_0_0_1_1_1_1, 0, 5, 0, 0, 1, 16'hFFFF);
    add(7'b0_0_0_1_1_1_1, 0, 0, 0, 0, 0, 16'h0000);
    // BRK hijacked by NMI falling in step 2; later syncs see no NMI
    add(7'b0_0_1_1_1_1_1, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 1, 1, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_0, 0, 2, 1, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_0, 0, 3, 1, 1, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_0, 0, 4, 0, 0, 0, 16'hFFFA);
    add(7'b0_0_0_1_1_1_0, 0, 5, 0, 0, 1, 16'hFFFB);
    add(7'b0_1_0_1_1_1_0, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_1_0_1_1_1_0, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 0, 0, 0, 0, 16'h0000);
    // NMI and IRQ together: NMI wins
    add(7'b0_0_0_1_0_0_0, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_0_0_0, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_1_0_1_0_0_0, 1, 0, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_0_0, 0, 1, 1, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_0_0, 0, 2, 1, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_0_0, 0, 3, 1, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_0_0, 0, 4, 0, 0, 0, 16'hFFFA);
    add(7'b0_0_0_1_1_0_0, 0, 5, 0, 0, 1, 16'hFFFB);
    add(7'b0_1_0_1_1_0_0, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 0, 0, 0, 0, 16'h0000);
    // IRQ stalled 3 cycles in step 3, then reset in step 4
    add(7'b0_0_0_1_0_0_1, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_1_0_1_0_0_1, 1, 0, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_0_1, 0, 1, 1, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_0_1, 0, 2, 1, 0, 0, 16'h0000);
    add(7'b0_0_0_0_1_0_1, 0, 3, 1, 0, 0, 16'h0000);
    add(7'b0_0_0_0_1_0_1, 0, 3, 1, 0, 0, 16'h0000);
    add(7'b0_0_0_0_1_0_1, 0, 3, 1, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_0_1, 0, 3, 1, 0, 0, 16'h0000);
    add(7'b1_0_0_1_1_0_1, 0, 4, 0, 0, 0, 16'hFFFE);
    add(7'b0_0_0_1_1_1_1, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_1_0_1_1_1_1, 1, 0, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 1, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 2, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 3, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 4, 0, 0, 0, 16'hFFFC);
    add(7'b0_0_0_1_1_1_1, 0, 5, 0, 0, 1, 16'hFFFD);
    add(7'b0_0_0_1_1_1_1, 0, 0, 0, 0, 0, 16'h0000);
    // BRK with ready low is not taken
    add(7'b0_1_1_0_1_1_1, 0, 0, 0, 0, 0, 16'h0000);
    add(7'b0_0_0_1_1_1_1, 0, 0, 0, 0, 0, 16'h0000);

    apply(7'b1_0_0_1_1_1_1);
    repeat (2) @(posedge clk);

    @(negedge clk);
    act = {bus.irq_force, bus.busy, bus.step, bus.vec_addr, bus.stack_wr, bus.b_flag,
           bus.set_i};
    checks++;
    if (act !== 24'h000000) begin
      failures++;
      $display("FAIL reset state: outputs=%h, want all zero", act);
    end

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      apply(tbl[i].in);
      sb.push_back(tbl[i].exp);
      @(negedge clk);
      act = {bus.irq_force, bus.busy, bus.step, bus.vec_addr, bus.stack_wr, bus.b_flag,
             bus.set_i};
      exp = sb.pop_front();
      checks++;
      if (act !== exp) begin
        failures++;
        $display({"FAIL row %0d: got force=%b busy=%b step=%0d vec=%h stack_wr=%b b_flag=%b ",
                  "set_i=%b, want force=%b busy=%b step=%0d vec=%h stack_wr=%b b_flag=%b set_i=%b"},
                 i, act[23], act[22], act[21:19], act[18:3], act[2], act[1], act[0],
                 exp[23], exp[22], exp[21:19], exp[18:3], exp[2], exp[1], exp[0]);
      end
    end

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
